// File: rtl/sdram_init_ctrl_if.sv
`timescale 1ns/1ps
// Init-sequencer command bus toward the SDRAM pins / bus arbiter.
// Master drives the command, bank, address and completion flag; slave observes them.
interface sdram_init_ctrl_if;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_end;

    modport master (
        output init_cmd,
        output init_ba,
        output init_addr,
        output init_end
    );

    modport slave (
        input init_cmd,
        input init_ba,
        input init_addr,
        input init_end
    );
endinterface

// File: rtl/sdram_init_ctrl.sv
`timescale 1ns/1ps
// SDR SDRAM power-up sequencer: wait, PRECHARGE ALL, AR_NUM x AUTO REFRESH, LOAD MODE, then init_end.
// Moore outputs decoded from the registered state; no backpressure, the bus is owned until init_end.
module sdram_init_ctrl #(
    parameter int          T_POWER  = 10000,
    parameter int          TRP_CLK  = 2,
    parameter int          TRFC_CLK = 7,
    parameter int          TMRD_CLK = 3,
    parameter int          AR_NUM   = 8,
    parameter logic [12:0] MODE_REG = 13'b0_0000_0011_0111
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    sdram_init_ctrl_if.master  init_bus
);

    localparam int PWR_W_RAW = $clog2(T_POWER);
    localparam int PWR_W     = (PWR_W_RAW > 14) ? PWR_W_RAW : 14;
    localparam int AR_W_RAW  = $clog2(AR_NUM + 1);
    localparam int AR_W      = (AR_W_RAW > 4) ? AR_W_RAW : 4;
    localparam int CYC_MAX_A = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
    localparam int CYC_MAX   = (CYC_MAX_A > TMRD_CLK) ? CYC_MAX_A : TMRD_CLK;
    localparam int CYC_W_RAW = $clog2(CYC_MAX);
    localparam int CYC_W     = (CYC_W_RAW > 3) ? CYC_W_RAW : 3;

    localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(T_POWER - 1);
    localparam logic [CYC_W-1:0] TRP_LAST  = CYC_W'(TRP_CLK - 1);
    localparam logic [CYC_W-1:0] TRFC_LAST = CYC_W'(TRFC_CLK - 1);
    localparam logic [CYC_W-1:0] TMRD_LAST = CYC_W'(TMRD_CLK - 1);
    localparam logic [AR_W-1:0]  AR_TOTAL  = AR_W'(AR_NUM);

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_AR,
        S_TRF,
        S_MRS,
        S_TMRD,
        S_END
    } state_t;

    state_t             state_q,   state_d;
    logic [PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [AR_W-1:0]    ar_cnt_q,  ar_cnt_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;

    logic [3:0]         cmd;
    logic [1:0]         ba;
    logic [12:0]        addr;
    logic               done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            pwr_cnt_q <= '0;
            ar_cnt_q  <= '0;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            ar_cnt_q  <= ar_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        ar_cnt_d  = ar_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // Power counter stops at its terminal value rather than wrapping.
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d = S_PRE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                end
            end
            S_PRE: state_d = S_TRP;
            S_TRP: begin
                if (cyc_cnt_q == TRP_LAST) state_d = S_AR;
            end
            S_AR: begin
                ar_cnt_d = ar_cnt_q + AR_W'(1);
                state_d  = S_TRF;
            end
            S_TRF: begin
                if (cyc_cnt_q == TRFC_LAST) begin
                    state_d = (ar_cnt_q < AR_TOTAL) ? S_AR : S_MRS;
                end
            end
            S_MRS: state_d = S_TMRD;
            S_TMRD: begin
                if (cyc_cnt_q == TMRD_LAST) state_d = S_END;
            end
            S_END:   state_d = S_END;
            default: state_d = S_IDLE;
        endcase
    end

    // Cycle counter only runs inside the NOP wait states and restarts on every transition.
    always_comb begin
        cyc_cnt_d = '0;
        if (state_d == state_q &&
            (state_q == S_TRP || state_q == S_TRF || state_q == S_TMRD)) begin
            cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
    end

    always_comb begin
        cmd  = CMD_NOP;
        ba   = 2'b11;
        addr = 13'h1FFF;
        done = 1'b0;
        unique case (state_q)
            S_PRE:   cmd = CMD_PRECHARGE;
            S_AR:    cmd = CMD_AREF;
            S_MRS: begin
                cmd  = CMD_LMR;
                ba   = 2'b00;
                addr = MODE_REG;
            end
            S_END:   done = 1'b1;
            default: cmd = CMD_NOP;
        endcase
    end

    assign init_bus.init_cmd  = cmd;
    assign init_bus.init_ba   = ba;
    assign init_bus.init_addr = addr;
    assign init_bus.init_end  = done;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
`timescale 1ns/1ps
// Bench for sdram_init_ctrl: every cycle is compared against an arithmetic timeline model,
// with directed and randomly placed mid-sequence resets.
module tb_sdram_init_ctrl;

    localparam int          T_POWER  = 10000;
    localparam int          TRP_CLK  = 2;
    localparam int          TRFC_CLK = 7;
    localparam int          TMRD_CLK = 3;
    localparam int          AR_NUM   = 8;
    localparam logic [12:0] MODE_REG = 13'b0_0000_0011_0111;

    localparam int PRE_AT = T_POWER;
    localparam int AR0_AT = T_POWER + 1 + TRP_CLK;
    localparam int MRS_AT = AR0_AT + AR_NUM * (1 + TRFC_CLK);
    localparam int END_AT = MRS_AT + 1 + TMRD_CLK;

    localparam logic [19:0] RESET_VEC = {4'b0111, 2'b11, 13'h1FFF, 1'b0};

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    sdram_init_ctrl_if bus ();

    sdram_init_ctrl #(
        .T_POWER (T_POWER),
        .TRP_CLK (TRP_CLK),
        .TRFC_CLK(TRFC_CLK),
        .TMRD_CLK(TMRD_CLK),
        .AR_NUM  (AR_NUM),
        .MODE_REG(MODE_REG)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .init_bus (bus.master)
    );

    always #10 sys_clk = ~sys_clk;

    // Expected {cmd, ba, addr, end} for cycle n counted from the first edge after reset release.
    function automatic logic [19:0] model(input int n);
        logic [19:0] v;
        v = RESET_VEC;
        if (n == PRE_AT) begin
            v = {4'b0010, 2'b11, 13'h1FFF, 1'b0};
        end else if (n >= AR0_AT && n < MRS_AT && ((n - AR0_AT) % (1 + TRFC_CLK)) == 0) begin
            v = {4'b0001, 2'b11, 13'h1FFF, 1'b0};
        end else if (n == MRS_AT) begin
            v = {4'b0000, 2'b00, MODE_REG, 1'b0};
        end else if (n >= END_AT) begin
            v = {4'b0111, 2'b11, 13'h1FFF, 1'b1};
        end
        return v;
    endfunction

    function automatic logic [19:0] observed();
        return {bus.init_cmd, bus.init_ba, bus.init_addr, bus.init_end};
    endfunction

    task automatic check(input string tag, input int n, input logic [19:0] obs, input logic [19:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs == exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks cycles 0..ncyc-1; returns 5 ns after the edge that begins cycle ncyc.
    task automatic run(input string tag, input int ncyc);
        int ar_obs;
        int ar_exp;
        logic [19:0] exp;
        ar_obs = 0;
        ar_exp = 0;
        for (int n = 0; n < ncyc; n++) begin
            exp = model(n);
            check(tag, n, observed(), exp);
            if (bus.init_cmd === 4'b0001) ar_obs++;
            if (exp[19:16] == 4'b0001) ar_exp++;
            @(posedge sys_clk);
            #5;
        end
        check_int({tag, "_ar_count"}, ar_obs, ar_exp);
    endtask

    // Asserts reset off-edge for one clock, checks the asynchronous response, releases on a falling edge.
    task automatic mid_reset(input string tag);
        sys_rst_n = 1'b0;
        #1;
        check({tag, "_async"}, -1, observed(), RESET_VEC);
        @(posedge sys_clk);
        #1;
        check({tag, "_held"}, -1, observed(), RESET_VEC);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int cut;
        sys_rst_n = 1'b0;
        #200;
        check("por_reset", -1, observed(), RESET_VEC);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;

        run("full", END_AT + 1000);

        mid_reset("rst_after_end");
        run("pre_cut", 10030);
        mid_reset("rst_10030");
        run("after_10030", END_AT + 20);

        for (int i = 0; i < 3; i++) begin
            mid_reset("rst_rand");
            cut = $urandom_range(END_AT + 40, 0);
            run("rand_cut", cut);
        end

        mid_reset("rst_final");
        run("final", END_AT + 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
